pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with valid/ready handshake and a two-entry elastic (skid) buffer. It carries PC, branch-delay flag, exception code and an opaque payload between two CPU stages. It generalises the fixed ID/EX-style latch to any stage boundary and any payload width. It keeps exception-redirect and flush priority, and adds a defined bubble PC/BD so EPC stays correct through stalls.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/pipe_stage_buf.sv | 114 +++++++++++
 tb/tb_pipe_stage_buf.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU stage definitions: exception codes, default PCs and the stage entry record.
package cpu_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned EXC_W = 5;

  // ExcCode values carried between stages
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [PC_W-1:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

  // Per-instruction bookkeeping that travels with every stage payload
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             bd;
    logic [EXC_W-1:0] exc;
  } stage_entry_t;

  // Elastic buffer fill level, encoded as the entry count
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// When empty it presents a bubble that keeps the PC/BD of the last issued entry.
module pipe_stage_buf
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = 128,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_state_t        state;
  stage_entry_t      head_ent;
  stage_entry_t      skid_ent;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] skid_data;
  logic [31:0]       bubble_pc;
  logic              bubble_bd;

  stage_entry_t      in_ent;
  logic              in_fire;
  logic              out_fire;
  logic              is_empty;

  // Handshake qualifiers; in_ready deliberately has no path from out_ready
  always_comb begin
    in_ent    = '{pc: in_pc, bd: in_bd, exc: in_exc};
    in_ready  = (state != OCC_TWO) & ~req & ~flush;
    is_empty  = (state == OCC_EMPTY);
    out_valid = ~is_empty;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Head entry or bubble onto the output bus
  always_comb begin
    occupancy = state;
    out_pc    = is_empty ? bubble_pc : head_ent.pc;
    out_bd    = is_empty ? bubble_bd : head_ent.bd;
    out_exc   = is_empty ? EXC_NONE  : head_ent.exc;
    out_data  = is_empty ? '0        : head_data;
  end

  // Occupancy FSM with reset > req > flush > handshake priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OCC_EMPTY;
      bubble_pc <= RESET_PC;
      bubble_bd <= 1'b0;
      head_ent  <= '0;
      skid_ent  <= '0;
      head_data <= '0;
      skid_data <= '0;
    end else if (req) begin
      state     <= OCC_EMPTY;
      bubble_pc <= HANDLER_PC;
      bubble_bd <= 1'b0;
    end else if (flush) begin
      state     <= OCC_EMPTY;
      bubble_pc <= out_pc;
      bubble_bd <= out_bd;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            head_ent  <= in_ent;
            head_data <= in_data;
            state     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            head_ent  <= in_ent;
            head_data <= in_data;
          end else if (in_fire) begin
            skid_ent  <= in_ent;
            skid_data <= in_data;
            state     <= OCC_TWO;
          end else if (out_fire) begin
            bubble_pc <= head_ent.pc;
            bubble_bd <= head_ent.bd;
            state     <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            head_ent  <= skid_ent;
            head_data <= skid_data;
            state     <= OCC_ONE;
          end
        end
        default: state <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized
// run against a queue-based model of a two-deep FIFO with a bubble register.
module tb_pipe_stage_buf;
  import cpu_pkg::*;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pc = '0;
  logic          in_bd = 1'b0;
  logic [4:0]    in_exc = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic          out_bd;
  logic [4:0]    out_exc;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0]   pc;
    logic          bd;
    logic [4:0]    exc;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_bubble_pc = 32'h0000_3000;
  logic        m_bubble_bd = 1'b0;

  pipe_stage_buf #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_bd(out_bd),
    .out_exc(out_exc), .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ready();
    return (q.size() != 2) && !req && !flush;
  endfunction
  function automatic logic [31:0] exp_pc();
    return (q.size() != 0) ? q[0].pc : m_bubble_pc;
  endfunction
  function automatic logic exp_bd();
    return (q.size() != 0) ? q[0].bd : m_bubble_bd;
  endfunction
  function automatic logic [4:0] exp_exc();
    return (q.size() != 0) ? q[0].exc : 5'd0;
  endfunction
  function automatic logic [DW-1:0] exp_data();
    return (q.size() != 0) ? q[0].data : '0;
  endfunction

  // Advance one clock edge and apply the same events to the model
  task automatic tick();
    logic        inf, outf;
    ent_t        e, f;
    logic [31:0] cpc;
    logic        cbd;
    inf  = in_valid && exp_ready();
    outf = (q.size() != 0) && out_ready;
    e    = '{pc: in_pc, bd: in_bd, exc: in_exc, data: in_data};
    cpc  = exp_pc();
    cbd  = exp_bd();
    @(posedge clk);
    if (reset) begin
      q.delete(); m_bubble_pc = 32'h0000_3000; m_bubble_bd = 1'b0;
    end else if (req) begin
      q.delete(); m_bubble_pc = 32'h0000_4180; m_bubble_bd = 1'b0;
    end else if (flush) begin
      q.delete(); m_bubble_pc = cpc; m_bubble_bd = cbd;
    end else begin
      f = '0;
      if (outf) f = q.pop_front();
      if (inf) q.push_back(e);
      if (outf && q.size() == 0) begin
        m_bubble_pc = f.pc; m_bubble_bd = f.bd;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic bd,
                        input logic [4:0] exc);
    in_valid = v; in_pc = pc; in_bd = bd; in_exc = exc;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=00003000", out_pc); end
    checks++; if (out_bd !== 1'b0 || out_exc !== 5'd0 || out_data !== '0) begin
      errors++; $display("FAIL reset_fields bd=%b exc=%0d data=%h exp=0", out_bd, out_exc, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_pass_through();
    logic [31:0] pcs [3];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, pcs[i], 1'b0, 5'd0);
      tick(); #2;
      checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i]) begin
        errors++; $display("FAIL pass_out%0d valid=%b pc=%h exp pc=%h", i, out_valid, out_pc, pcs[i]); end
      checks++; if (out_data !== exp_data() || occupancy !== 2'd1) begin
        errors++; $display("FAIL pass_data%0d occ=%0d data=%h exp=%h", i, occupancy, out_data, exp_data()); end
    end
    set_in(1'b0, '0, 1'b0, 5'd0); tick(); #2;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3008) begin
      errors++; $display("FAIL pass_drain valid=%b pc=%h exp 0/00003008", out_valid, out_pc); end
  endtask

  task automatic test_skid_fill();
    logic [31:0] a, b;
    a = 32'h3100; b = 32'h3104;
    out_ready = 1'b0;
    set_in(1'b1, a, 1'b0, 5'd4); tick();
    set_in(1'b1, b, 1'b1, 5'd10); tick();
    set_in(1'b1, 32'h3108, 1'b0, 5'd0); #2;
    checks++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      errors++; $display("FAIL skid_full in_ready=%b occ=%0d exp 0/2", in_ready, occupancy); end
    tick();
    set_in(1'b0, '0, 1'b0, 5'd0); out_ready = 1'b1; #2;
    checks++; if (out_pc !== a || out_exc !== 5'd4) begin
      errors++; $display("FAIL skid_head pc=%h exc=%0d exp %h/4", out_pc, out_exc, a); end
    tick(); #2;
    checks++; if (out_pc !== b || out_bd !== 1'b1 || out_exc !== 5'd10 || out_data !== exp_data()) begin
      errors++; $display("FAIL skid_second pc=%h bd=%b exc=%0d exp %h/1/10", out_pc, out_bd, out_exc, b); end
    tick(); #2;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL skid_empty valid=%b occ=%0d exp 0/0", out_valid, occupancy); end
  endtask

  task automatic test_bubble_bd();
    out_ready = 1'b1;
    set_in(1'b1, 32'h3010, 1'b1, 5'd12); tick();
    set_in(1'b0, '0, 1'b0, 5'd0); tick(); #2;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3010 || out_bd !== 1'b1) begin
      errors++; $display("FAIL bubble_pcbd valid=%b pc=%h bd=%b exp 0/00003010/1", out_valid, out_pc, out_bd); end
    checks++; if (out_exc !== 5'd0 || out_data !== '0) begin
      errors++; $display("FAIL bubble_zero exc=%0d data=%h exp 0", out_exc, out_data); end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    set_in(1'b1, 32'h3200, 1'b0, 5'd0); tick();
    set_in(1'b1, 32'h3204, 1'b1, 5'd0); tick();
    set_in(1'b1, 32'h3208, 1'b0, 5'd0); req = 1'b1; out_ready = 1'b1; #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL redirect_in_ready got=%b exp=0", in_ready); end
    tick();
    req = 1'b0; set_in(1'b0, '0, 1'b0, 5'd0); #2;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_occ occ=%0d valid=%b exp 0/0", occupancy, out_valid); end
    checks++; if (out_pc !== 32'h4180 || out_bd !== 1'b0) begin
      errors++; $display("FAIL redirect_pc pc=%h bd=%b exp 00004180/0", out_pc, out_bd); end
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h3020, 1'b1, 5'd0); tick();
    set_in(1'b0, '0, 1'b0, 5'd0); flush = 1'b1; #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick(); flush = 1'b0; #2;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3020 || out_bd !== 1'b1) begin
      errors++; $display("FAIL flush_bubble valid=%b pc=%h bd=%b exp 0/00003020/1", out_valid, out_pc, out_bd); end
    set_in(1'b1, 32'h3300, 1'b0, 5'd0); tick();
    reset = 1'b1; req = 1'b1; set_in(1'b1, 32'h3304, 1'b0, 5'd0); tick();
    reset = 1'b0; req = 1'b0; set_in(1'b0, '0, 1'b0, 5'd0); #2;
    checks++; if (out_pc !== 32'h3000 || occupancy !== 2'd0) begin
      errors++; $display("FAIL reset_over_req pc=%h occ=%0d exp 00003000/0", out_pc, occupancy); end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int c = 0; c < 10000; c++) begin
      req       = ($urandom_range(63) == 0);
      flush     = ($urandom_range(47) == 0);
      out_ready = ($urandom_range(99) < 60);
      set_in(($urandom_range(99) < 70), {$urandom_range(32'hFFFF), 2'b00} + 32'h3000,
             1'($urandom_range(1)), 5'($urandom_range(31)));
      #2;
      checks++;
      if (in_ready !== exp_ready() || out_valid !== (q.size() != 0) ||
          occupancy !== 2'(q.size())) begin
        errors++;
        if (shown++ < 20) $display("FAIL rand_ctrl c=%0d rdy=%b vld=%b occ=%0d exp %b/%b/%0d",
          c, in_ready, out_valid, occupancy, exp_ready(), q.size() != 0, q.size());
      end
      checks++;
      if (out_pc !== exp_pc() || out_bd !== exp_bd() || out_exc !== exp_exc() ||
          out_data !== exp_data()) begin
        errors++;
        if (shown++ < 20) $display("FAIL rand_head c=%0d pc=%h bd=%b exc=%0d exp %h/%b/%0d",
          c, out_pc, out_bd, out_exc, exp_pc(), exp_bd(), exp_exc());
      end
      tick();
    end
    req = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_skid_fill();
    test_bubble_bd();
    test_redirect();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
